// File: rtl/booth_pp_if.sv
// Handshake bundle between the Booth encoder (rows in) and the consumer of
// the finished 32-bit product (product out).
interface booth_pp_if;
  logic        pp_valid;
  logic        pp_ready;
  logic [16:0] pp_data;
  logic        pp_neg;
  logic        prod_valid;
  logic        prod_ready;
  logic [31:0] product;

  modport master (
    output pp_valid, pp_data, pp_neg, prod_ready,
    input  pp_ready, prod_valid, product
  );

  modport slave (
    input  pp_valid, pp_data, pp_neg, prod_ready,
    output pp_ready, prod_valid, product
  );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Sums NPP radix-4 Booth partial-product rows, each weighted by 4^idx,
// into one signed 32-bit product and hands it off over a valid/ready pair.
module booth_pp_accumulator #(
  parameter int unsigned NPP = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  booth_pp_if.slave bus
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned PP_W  = 17;
  localparam int unsigned EXT_W = ACC_W - PP_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPP - 1);
  localparam bit MULTI_ROW = (NPP > 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               pp_ready_q;
  logic               prod_valid_q;
  logic               accept_c;
  logic [ACC_W-1:0]   row_base_c;
  logic [ACC_W-1:0]   row_term_c;

  // Sign-extended row plus its negation bit, shifted to weight 4^idx.
  assign accept_c   = bus.pp_valid && pp_ready_q;
  assign row_base_c = {{EXT_W{bus.pp_data[PP_W-1]}}, bus.pp_data} + ACC_W'(bus.pp_neg);
  assign row_term_c = row_base_c << {idx_q, 1'b0};

  // Next-state, row counter and accumulator update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (accept_c) begin
          acc_d = row_term_c;
          if (MULTI_ROW) begin
            state_d = ACCUM;
            idx_d   = IDX_W'(1);
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        if (accept_c) begin
          acc_d = acc_q + row_term_c;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        if (bus.prod_ready) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        acc_d   = '0;
      end
    endcase
    // Flush wins over any beat arriving on the same edge.
    if (clr) begin
      state_d = IDLE;
      idx_d   = '0;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      pp_ready_q   <= 1'b1;
      prod_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      pp_ready_q   <= (state_d != DONE);
      prod_valid_q <= (state_d == DONE);
    end
  end

  assign bus.pp_ready   = pp_ready_q;
  assign bus.prod_valid = prod_valid_q;
  assign bus.product    = acc_q;

endmodule

// File: doc/booth_pp_accumulator.md
BOOTH_PP_ACCUMULATOR -- requirements
Module: booth_pp_accumulator

Interface
REQ-001 The block SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter NPP, default 8, SHALL set the number of radix-4 Booth partial products per 16x16 signed product.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 pp_valid  input  1  upstream partial product present.
REQ-006 pp_ready  output  1  block can accept a partial product this cycle.
REQ-007 pp_data  input  17  Booth-encoder row (X, 2X, or its bitwise inverse, or zero), two's complement.
REQ-008 pp_neg  input  1  negation correction bit; +1 at the row's LSB weight.
REQ-009 clr  input  1  synchronous flush of any partial accumulation.
REQ-010 prod_valid  output  1  product present.
REQ-011 prod_ready  input  1  downstream accepts product.
REQ-012 product  output  32  signed 32-bit result.

Function
REQ-013 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-014 A beat SHALL be accepted when pp_valid and pp_ready are both 1 on a rising clk edge.
REQ-015 pp_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-016 A 3-bit row counter idx SHALL be cleared in IDLE and SHALL increment on each accepted beat.
REQ-017 Each accepted beat SHALL add (sign_extend_32(pp_data) + pp_neg) << (2*idx) to a 32-bit accumulator.
REQ-018 The first accepted beat (in IDLE) SHALL load the accumulator with its row term instead of adding to the prior value.
REQ-019 Accumulator arithmetic SHALL be modulo 2^32; carries out of bit 31 SHALL be discarded.
REQ-020 IDLE SHALL go to ACCUM on an accepted beat when NPP > 1.
REQ-021 ACCUM SHALL stay in ACCUM while idx < NPP-1 and SHALL go to DONE on the accepted beat with idx = NPP-1.
REQ-022 When no beat is accepted (pp_valid low), state, idx and accumulator SHALL hold.
REQ-023 prod_valid SHALL be 1 only in DONE.
REQ-024 product SHALL equal the accumulator in DONE and SHALL hold stable while prod_valid=1 and prod_ready=0.
REQ-025 DONE SHALL go to IDLE on the cycle prod_ready=1; pp_ready SHALL rise on the following cycle.
REQ-026 Latency SHALL be: prod_valid rises on the cycle after the NPP-th accepted beat; minimum period NPP+1 cycles per product.
REQ-027 clr=1 SHALL force IDLE, idx=0 and accumulator=0 on the next edge, in any state, discarding any in-flight or unconsumed product.
REQ-028 If clr and an accepted beat coincide, the beat SHALL be discarded.
REQ-029 If rst and clr coincide, rst SHALL take effect.
REQ-030 pp_neg=1 with pp_data = bitwise-inverted X SHALL yield exactly -X for that row.

Reset
REQ-031 On rst=1 at a clk edge: state=IDLE, idx=0, accumulator=0, product=0x00000000, prod_valid=0, pp_ready=1 from the next cycle.
REQ-032 rst asserted mid-accumulation or in DONE SHALL discard the partial or pending product, with no prod_valid pulse.

Verification
REQ-033 A=3, B=5, rows {0x00003,n0}, {0x00003,n0}, then six {0,n0} -> product=0x0000000F, prod_valid on the cycle after the 8th beat.
REQ-034 A=-1, B=2, rows {0x00001,n1}, {0x1FFFF,n0}, then six zero rows -> product=0xFFFFFFFE.
REQ-035 A=B=-32768, full Booth rows from the encoder model -> product=0x40000000; random 10k A,B pairs checked against A*B.
REQ-036 Hold prod_ready=0 for 5 cycles in DONE with pp_valid=1 -> product stable, pp_ready=0, no beat accepted; prod_ready=1 -> IDLE, pp_ready=1 next cycle.
REQ-037 pp_valid gaps (1 cycle on, 2 off) during accumulation -> same result as back-to-back delivery.
REQ-038 clr asserted after 4 beats, then 8 fresh rows -> only the fresh product is reported; rst in DONE -> prod_valid=0 next cycle.
